// File: rtl/mc_control_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// It holds the state encodings, the opcode/funct/ALU codes and the per-state control word.
package mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       regwrite;
    logic       retire;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_legal = 1'b1;
      default:                                       opcode_legal = 1'b0;
    endcase
  endfunction

  // Moore control word for a state; anything not set here stays 0.
  function automatic ctrl_t ctrl_for_state(input state_t s);
    ctrl_t c;
    c       = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = 2'b01;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.retire   = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_ADDIWB: begin
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.branch  = 1'b1;
        c.pcsrc   = 2'b01;
        c.aluop   = ALUOP_SUB;
        c.retire  = 1'b1;
      end
      S_JUMP: begin
        c.pcwrite = 1'b1;
        c.pcsrc   = 2'b10;
        c.retire  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU-control decode: maps (ALUOp, funct) to the 3-bit ALU operation.
// funct_illegal flags an unsupported funct while in funct mode.
module mc_alu_decoder
  import mc_control_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [2:0] ALUControl,
  output logic       funct_illegal
);

  always_comb begin
    ALUControl    = ALUC_ADD;
    funct_illegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALUC_ADD;
      ALUOP_SUB: ALUControl = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  ALUControl = ALUC_ADD;
          FN_SUB:  ALUControl = ALUC_SUB;
          FN_AND:  ALUControl = ALUC_AND;
          FN_OR:   ALUControl = ALUC_OR;
          FN_SLT:  ALUControl = ALUC_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: ALUControl = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing a shared-memory, single-ALU datapath.
// Define MC_CONTROL_MEMREADY_EN to stall FETCH/MEMRD/MEMWR until mem_ready.
module mc_control_unit
  import mc_control_pkg::*;
#(
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              IorD,
  output logic              ALUSrcA,
  output logic              RegDst,
  output logic              MemtoReg,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        PCSrc,
  output logic              IRWrite,
  output logic              PCWrite,
  output logic              Branch,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              PCEn,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              illegal,
  output logic              instr_done,
  output logic [3:0]        state
);

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl_q;
  logic       mem_ok;
  logic       stall;
  logic       op_legal;
  logic       funct_illegal;
  logic       pcwrite_eff;
  logic [2:0] aluc3;

`ifdef MC_CONTROL_MEMREADY_EN
  assign mem_ok = mem_ready;
`else
  // Handshake disabled: memory is always ready; OR keeps the port referenced.
  assign mem_ok = mem_ready | 1'b1;
`endif

  assign op_legal = opcode_legal(opcode);
  assign stall    = ~mem_ok & ((state_q == S_FETCH) | (state_q == S_MEMRD) |
                               (state_q == S_MEMWR));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Control word is registered alongside the state so outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= ctrl_for_state(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for_state(state_d);
    end
  end

  mc_alu_decoder u_alu_decoder (
    .ALUOp         (ctrl_q.aluop),
    .funct         (funct),
    .ALUControl    (aluc3),
    .funct_illegal (funct_illegal)
  );

  assign pcwrite_eff = ctrl_q.pcwrite & ~stall & ~reset;

  assign IorD     = ctrl_q.iord;
  assign ALUSrcA  = ctrl_q.alusrca;
  assign RegDst   = ctrl_q.regdst;
  assign MemtoReg = ctrl_q.memtoreg;
  assign ALUSrcB  = ctrl_q.alusrcb;
  assign PCSrc    = ctrl_q.pcsrc;
  assign Branch   = ctrl_q.branch;
  assign IRWrite  = ctrl_q.irwrite & ~stall & ~reset;
  assign PCWrite  = pcwrite_eff;
  assign MemWrite = ctrl_q.memwrite & ~reset;
  assign RegWrite = ctrl_q.regwrite & ~reset;
  assign PCEn     = (pcwrite_eff | (ctrl_q.branch & zero)) & ~reset;
  assign state    = state_q;

  assign illegal = ~reset & (((state_q == S_DECODE) & ~op_legal) |
                             ((state_q == S_EXECUTE) & funct_illegal));

  // A stalled MEMWR keeps MemWrite high but retires only on its ready cycle.
  assign instr_done = ~reset & ((ctrl_q.retire & ~stall) |
                                ((state_q == S_DECODE) & ~op_legal));

  always_comb begin
    ALUControl      = '0;
    ALUControl[2:0] = aluc3;
  end

endmodule
